// File: rtl/icache_sa_ctrl.sv
// N-way set-associative instruction cache with a miss/refill FSM, round-robin replacement and flush.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_sa_ctrl #(
  parameter int WAYS       = 2,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req,
  input  logic [ADDR_W-1:0]        addr,
  input  logic                     flush,
  output logic                     ready,
  output logic [31:0]              inst,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_ready,
  input  logic [LINE_WORDS*32-1:0] mem_line
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]              hit_cnt,
  output logic [31:0]              miss_cnt
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;
  typedef enum logic [1:0] {IDLE, REFILL, FILL} state_t;

  state_t           state;
  logic             flush_pend;
  logic [WAYS-1:0]  valid    [SETS];
  logic [WAY_W-1:0] rr_ptr   [SETS];
  line_t            data_mem [WAYS][SETS];
  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];

  line_t            fill_line;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  logic [OFF_W-1:0] lk_off;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;
  logic             lookup_hit;
  logic             miss_start;
  logic [WAY_W-1:0] victim;
  logic             victim_valid;
  logic [WAY_W-1:0] rr_next;
  logic             unused_addr_bits;

  assign lk_off           = addr[2 +: OFF_W];
  assign lk_idx           = addr[2+OFF_W +: IDX_W];
  assign lk_tag           = addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^addr[1:0];

  // Tag compare across all ways; at most one way can match.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[lk_idx][WAY_W'(w)] && (tag_mem[WAY_W'(w)][lk_idx] == lk_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign lookup_hit = (state == IDLE) && !reset && req && !flush && hit_any;
  assign miss_start = (state == IDLE) && req && !flush && !hit_any;
  assign ready      = lookup_hit;
  assign inst       = lookup_hit ? data_mem[hit_way][lk_idx][lk_off] : 32'd0;

  // Prefer the lowest invalid way; fall back to the set's round-robin pointer.
  always_comb begin
    victim       = rr_ptr[fill_idx];
    victim_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[fill_idx][WAY_W'(w)]) begin
        victim       = WAY_W'(w);
        victim_valid = 1'b0;
      end
    end
    rr_next = (rr_ptr[fill_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[fill_idx] + WAY_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      flush_pend <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
          end else if (miss_start) begin
            state    <= REFILL;
            mem_req  <= 1'b1;
            mem_addr <= {addr[ADDR_W-1:2+OFF_W], {(2+OFF_W){1'b0}}};
            fill_idx <= lk_idx;
            fill_tag <= lk_tag;
          end
        end
        REFILL: begin
          if (flush) flush_pend <= 1'b1;
          if (mem_ready) begin
            mem_req   <= 1'b0;
            fill_line <= mem_line;
            state     <= FILL;
          end
        end
        FILL: begin
          state <= IDLE;
          // A flush seen during the refill wins over the new line's valid bit.
          if (flush_pend || flush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
            flush_pend <= 1'b0;
          end else begin
            valid[fill_idx][victim] <= 1'b1;
          end
          if (victim_valid) rr_ptr[fill_idx] <= rr_next;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL) begin
      data_mem[victim][fill_idx] <= fill_line;
      tag_mem[victim][fill_idx]  <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit) hit_cnt  <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_sa_ctrl.sv
// Directed bench for icache_sa_ctrl at default parameters (2 ways, 16 sets, 4-word lines).
// Stats checks are compiled only when ICACHE_STATS_EN is defined.
module tb_icache_sa_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req = 1'b0;
  logic [31:0]  addr = '0;
  logic         flush = 1'b0;
  logic         ready;
  logic [31:0]  inst;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ready = 1'b0;
  logic [127:0] mem_line = '0;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  icache_sa_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .addr      (addr),
    .flush     (flush),
    .ready     (ready),
    .inst      (inst),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_line  (mem_line)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; req = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    tick();
    #1;
    check_eq("reset ready", ready, 1'b0);
    check_eq("reset inst", inst, 32'd0);
    check_eq("reset mem_req", mem_req, 1'b0);
`ifdef ICACHE_STATS_EN
    check_eq("reset hit_cnt", hit_cnt, 32'd0);
    check_eq("reset miss_cnt", miss_cnt, 32'd0);
`endif
    reset = 1'b0;
  endtask

  // Miss on a, serve the line on the first REFILL cycle, then expect a hit returning exp_inst.
  task automatic fill(input logic [31:0] a, input logic [127:0] line, input logic [31:0] exp_inst,
                      input string tag);
    tick();
    req = 1'b1; addr = a;
    #1;
    check_eq({tag, " miss ready"}, ready, 1'b0);
    tick();
    req = 1'b0;
    #1;
    check_eq({tag, " mem_req"}, mem_req, 1'b1);
    check_eq({tag, " mem_addr"}, mem_addr, a & ~32'hF);
    mem_ready = 1'b1; mem_line = line;
    tick();
    mem_ready = 1'b0;
    #1;
    check_eq({tag, " fill mem_req"}, mem_req, 1'b0);
    check_eq({tag, " fill ready"}, ready, 1'b0);
    tick();
    req = 1'b1; addr = a;
    #1;
    check_eq({tag, " hit ready"}, ready, 1'b1);
    check_eq({tag, " hit inst"}, inst, exp_inst);
  endtask

  task automatic probe(input logic [31:0] a, input logic exp_rdy, input logic [31:0] exp_inst,
                       input string tag);
    tick();
    req = 1'b1; addr = a;
    #1;
    check_eq({tag, " ready"}, ready, exp_rdy);
    check_eq({tag, " inst"}, inst, exp_inst);
    if (!exp_rdy) req = 1'b0;
  endtask

  task automatic finish_refill(input logic [127:0] line);
    mem_ready = 1'b1; mem_line = line;
    tick();
    mem_ready = 1'b0;
    tick();
  endtask

  localparam logic [127:0] LA   = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] L40  = 128'h40000003_40000002_40000001_40000000;
  localparam logic [127:0] L140 = 128'h14000003_14000002_14000001_14000000;
  localparam logic [127:0] L240 = 128'h24000003_24000002_24000001_24000000;
  localparam logic [127:0] L340 = 128'h34000003_34000002_34000001_34000000;
  localparam logic [127:0] L80  = 128'h80000003_80000002_80000001_80000000;
  localparam logic [127:0] LC0  = 128'hC0000003_C0000002_C0000001_C0000000;

  initial begin
    // Cold miss on 0x48, word 2 of the line, then a same-line hit on 0x44.
    do_reset();
    fill(32'h48, LA, 32'hAAAA0002, "t1");
    probe(32'h44, 1'b1, 32'hAAAA0001, "t1 0x44");

    // Flush in IDLE.
    tick();
    req = 1'b1; addr = 32'h48; flush = 1'b1;
    #1;
    check_eq("t3 flush ready", ready, 1'b0);
    check_eq("t3 flush inst", inst, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check_eq("t3 no miss in flush cycle", mem_req, 1'b0);
    check_eq("t3 post-flush ready", ready, 1'b0);
    tick();
    req = 1'b0;
    #1;
    check_eq("t3 mem_req", mem_req, 1'b1);
    check_eq("t3 mem_addr", mem_addr, 32'h40);
    finish_refill(LA);
    probe(32'h48, 1'b1, 32'hAAAA0002, "t3 refilled");

    // Replacement within set 4.
    do_reset();
    fill(32'h040, L40, 32'h40000000, "t2 0x040");
    fill(32'h140, L140, 32'h14000000, "t2 0x140");
    probe(32'h040, 1'b1, 32'h40000000, "t2 0x040 hit");
    probe(32'h140, 1'b1, 32'h14000000, "t2 0x140 hit");
    fill(32'h240, L240, 32'h24000000, "t2 0x240");
    probe(32'h040, 1'b0, 32'd0, "t2 0x040 evicted");
    probe(32'h140, 1'b1, 32'h14000000, "t2 0x140 kept");
    probe(32'h240, 1'b1, 32'h24000000, "t2 0x240 hit");
    fill(32'h340, L340, 32'h34000000, "t2 0x340");
    probe(32'h140, 1'b0, 32'd0, "t2 0x140 evicted");
    probe(32'h240, 1'b1, 32'h24000000, "t2 0x240 kept");
    probe(32'h344, 1'b1, 32'h34000001, "t2 0x344 hit");

    // Flush during REFILL.
    tick();
    req = 1'b1; addr = 32'h80;
    #1;
    check_eq("t4 miss ready", ready, 1'b0);
    tick();
    req = 1'b0;
    #1;
    check_eq("t4 mem_req", mem_req, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check_eq("t4 mem_req held", mem_req, 1'b1);
    mem_ready = 1'b1; mem_line = L80;
    tick();
    mem_ready = 1'b0;
    #1;
    check_eq("t4 fill mem_req", mem_req, 1'b0);
    tick();
    req = 1'b1; addr = 32'h80;
    #1;
    check_eq("t4 remiss ready", ready, 1'b0);
    tick();
    req = 1'b0;
    #1;
    check_eq("t4 remiss mem_req", mem_req, 1'b1);
    check_eq("t4 remiss mem_addr", mem_addr, 32'h80);
    finish_refill(L80);
    probe(32'h240, 1'b0, 32'd0, "t4 0x240 flushed");
    probe(32'h88, 1'b1, 32'h80000002, "t4 0x88 hit");

    // Reset mid-REFILL.
    tick();
    req = 1'b1; addr = 32'hC0;
    #1;
    tick();
    req = 1'b0;
    #1;
    check_eq("t5 mem_req", mem_req, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("t5 reset mem_req", mem_req, 1'b0);
    check_eq("t5 reset ready", ready, 1'b0);
    mem_ready = 1'b1; mem_line = LC0;
    tick();
    mem_ready = 1'b0;
    #1;
    check_eq("t5 ignored mem_ready", mem_req, 1'b0);
    probe(32'h80, 1'b0, 32'd0, "t5 0x80 lost");
    probe(32'hC0, 1'b0, 32'd0, "t5 0xC0 not filled");

`ifdef ICACHE_STATS_EN
    // Two misses and five hit cycles from a cold cache.
    do_reset();
    fill(32'h040, L40, 32'h40000000, "t6 0x40");
    probe(32'h044, 1'b1, 32'h40000001, "t6 0x44");
    probe(32'h048, 1'b1, 32'h40000002, "t6 0x48");
    fill(32'h140, L140, 32'h14000000, "t6 0x140");
    probe(32'h144, 1'b1, 32'h14000001, "t6 0x144");
    tick();
    req = 1'b0;
    #1;
    check_eq("t6 miss_cnt", miss_cnt, 32'd2);
    check_eq("t6 hit_cnt", hit_cnt, 32'd5);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
